// File: rtl/register_file_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational and see same-cycle writeback data and releases.
module register_file_sb #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    NUM_REGS     = 32,
  parameter int                    NUM_REGS_LOG = $clog2(NUM_REGS),
  parameter int                    NUM_READ     = 2,
  parameter int                    NUM_WRITE    = 2,
  parameter int                    SP_INDEX     = 2,
  parameter logic [DATA_WIDTH-1:0] SP_INIT      = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*NUM_REGS_LOG-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic [NUM_WRITE-1:0]              wr_en,
  input  logic [NUM_WRITE*NUM_REGS_LOG-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
  input  logic                              rsv_en,
  input  logic [NUM_REGS_LOG-1:0]           rsv_addr,
  input  logic                              flush,
  output logic [NUM_REGS-1:0]               busy_vec
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  // Later ports overwrite earlier ones, so the highest-numbered port wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w] && wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG] != '0) begin
        regs_d[wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        busy_d[wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG]] = 1'b0;
      end
    end
    // A reservation is a newer producer than any same-cycle writeback.
    if (flush) begin
      busy_d = '0;
    end else if (rsv_en && rsv_addr != '0) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [NUM_REGS_LOG-1:0] ra;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    wr_hit;
    logic                    rsv_hit;

    assign ra = rd_addr[p*NUM_REGS_LOG +: NUM_REGS_LOG];

    always_comb begin
      rdata  = (ra == '0) ? '0 : regs_q[ra];
      wr_hit = 1'b0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && ra != '0 && wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG] == ra) begin
          rdata  = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          wr_hit = 1'b1;
        end
      end
    end

    assign rsv_hit = rsv_en && (rsv_addr == ra);
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign rd_busy[p] = busy_q[ra] && !(wr_hit && !rsv_hit);
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: each step drives ports just after the rising edge and queues
// expected outputs; a negedge monitor pops and compares them.
module tb_register_file_sb;
  localparam int DW = 64;
  localparam int L  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*L-1:0]  rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*L-1:0]  wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            rsv_en;
  logic [L-1:0]    rsv_addr;
  logic            flush;
  logic [31:0]     busy_vec;

  localparam int K_D0 = 0, K_D1 = 1, K_RB = 2, K_BV = 3;

  logic [DW-1:0] exp_q[$];
  int            kind_q[$];
  int            total = 0;
  int            bad   = 0;

  register_file_sb #(
    .DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2),
    .SP_INDEX(2), .SP_INIT(64'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_D0:    return "rd_data0";
      K_D1:    return "rd_data1";
      K_RB:    return "rd_busy";
      default: return "busy_vec";
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [DW-1:0] e;
      logic [DW-1:0] a;
      int            k;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      case (k)
        K_D0:    a = rd_data[DW-1:0];
        K_D1:    a = rd_data[2*DW-1:DW];
        K_RB:    a = {62'd0, rd_busy};
        default: a = {32'd0, busy_vec};
      endcase
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s t=%0t actual=%h required=%h", kname(k), $time, a, e);
      end
    end
  end

  task automatic expect_val(input int k, input logic [DW-1:0] v);
    kind_q.push_back(k);
    exp_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [L-1:0] a0, input logic [L-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [L-1:0] a0, input logic [DW-1:0] d0,
                        input logic [L-1:0] a1, input logic [DW-1:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  initial begin
    reset = 1'b0; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    set_rd(0, 0); set_wr(2'b00, 0, 0, 0, 0);
    repeat (2) tick();

    // Reset contents
    set_rd(2, 5);
    expect_val(K_D0, 64'h8000_0000); expect_val(K_D1, 64'h0);
    expect_val(K_BV, 64'h0); expect_val(K_RB, 64'h0);
    tick();
    reset = 1'b1;

    // Bypass write to x5
    set_wr(2'b01, 5, 64'hDEAD, 0, 0); set_rd(5, 2);
    expect_val(K_D0, 64'hDEAD); expect_val(K_D1, 64'h8000_0000);
    tick();
    set_wr(2'b00, 0, 0, 0, 0);
    expect_val(K_D0, 64'hDEAD);
    tick();

    // Conflicting writes to x7
    set_wr(2'b11, 7, 64'h11, 7, 64'h22); set_rd(7, 7);
    expect_val(K_D0, 64'h22); expect_val(K_D1, 64'h22);
    tick();
    set_wr(2'b01, 0, 64'hFF, 0, 0); set_rd(7, 0);
    expect_val(K_D0, 64'h22); expect_val(K_D1, 64'h0);
    tick();

    // Reserve x9, then release it by writeback
    set_wr(2'b00, 0, 0, 0, 0); rsv_en = 1'b1; rsv_addr = 9;
    expect_val(K_D1, 64'h0); expect_val(K_BV, 64'h0);
    tick();
    rsv_en = 1'b0; set_rd(9, 0);
    expect_val(K_BV, 64'h200); expect_val(K_RB, 64'h1);
    tick();
    set_wr(2'b10, 0, 0, 9, 64'h99);
    expect_val(K_RB, 64'h0); expect_val(K_D0, 64'h99); expect_val(K_BV, 64'h200);
    tick();

    // Reserve and write x9 together: reservation survives
    set_wr(2'b01, 9, 64'hAA, 0, 0); rsv_en = 1'b1; rsv_addr = 9;
    expect_val(K_BV, 64'h0); expect_val(K_RB, 64'h0); expect_val(K_D0, 64'hAA);
    tick();
    set_wr(2'b00, 0, 0, 0, 0); rsv_en = 1'b1; rsv_addr = 3; flush = 1'b1; set_rd(9, 3);
    expect_val(K_BV, 64'h200); expect_val(K_RB, 64'h1); expect_val(K_D0, 64'hAA);
    tick();
    rsv_en = 1'b0; flush = 1'b0;
    expect_val(K_BV, 64'h0); expect_val(K_RB, 64'h0); expect_val(K_D0, 64'hAA);
    tick();

    // Reserve x4 with a same-cycle write, then async reset
    set_wr(2'b01, 4, 64'h44, 0, 0); rsv_en = 1'b1; rsv_addr = 4; set_rd(4, 2);
    tick();
    set_wr(2'b00, 0, 0, 0, 0); rsv_en = 1'b0;
    expect_val(K_BV, 64'h10); expect_val(K_D0, 64'h44); expect_val(K_RB, 64'h1);
    tick();
    #1 reset = 1'b0;
    expect_val(K_BV, 64'h0); expect_val(K_D0, 64'h0);
    expect_val(K_D1, 64'h8000_0000); expect_val(K_RB, 64'h0);
    tick();
    reset = 1'b1; set_rd(7, 9);
    expect_val(K_D0, 64'h0); expect_val(K_D1, 64'h0);
    tick();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
